// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and size defaults for the carry-save resolver
package csa_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int WIDTH_DEF   = 15;
    localparam int SLICE_W_DEF = 5;
    localparam int NUM_SLICES  = WIDTH_DEF / SLICE_W_DEF;
endpackage

// File: rtl/csa_slice_add.sv
// csa_slice_add: SLICE_W-bit ripple slice adder
// ports: a, b, cin -> sum, cout
module csa_slice_add #(
    parameter int SLICE_W = 5
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
endmodule

// File: rtl/csa_resolve15.sv
// csa_resolve15: resolves a carry-save pair into a binary sum, one slice per cycle
// ports: clk, rst_n (async, active-low); in_valid/in_ready + carry_vec/sum_vec in;
//        out_valid/out_ready + result/ovf out
module csa_resolve15 import csa_pkg::*; #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] carry_vec,
    input  logic [WIDTH-1:0] sum_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    localparam int NS = WIDTH / SLICE_W;
    localparam int KW = NS > 1 ? $clog2(NS) : 1;
    state_e                   state_q, state_d;
    logic [NS-1:0][SLICE_W-1:0] opc_q, opc_d, ops_q, ops_d, res_q, res_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     cy_q, cy_d, ovf_q, ovf_d;
    logic [SLICE_W-1:0]       sl_sum;
    logic                     sl_cout;
    logic                     in_xfer;
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign in_xfer   = in_valid && in_ready;
    assign result    = res_q;
    assign ovf       = ovf_q;
    // single adder shared by all slices, selected by the slice index
    csa_slice_add #(.SLICE_W(SLICE_W)) u_slice (
        .a    (opc_q[k_q]),
        .b    (ops_q[k_q]),
        .cin  (cy_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        ops_d   = ops_q;
        res_d   = res_q;
        k_d     = k_q;
        cy_d    = cy_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            res_d[k_q] = sl_sum;
            cy_d       = sl_cout;
            k_d        = k_q + KW'(1);
            if (k_q == KW'(NS - 1)) begin
                state_d = DONE;
                ovf_d   = sl_cout;
                k_d     = '0;
            end
        end
        if (state_q == DONE && out_ready) state_d = IDLE;
        // a capture in DONE overrides the return to IDLE for back-to-back operation
        if (in_xfer) begin
            state_d = RUN;
            opc_d   = carry_vec;
            ops_d   = sum_vec;
            k_d     = '0;
            cy_d    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opc_q   <= '0;
            ops_q   <= '0;
            res_q   <= '0;
            k_q     <= '0;
            cy_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            k_q     <= k_d;
            cy_q    <= cy_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
